// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers and a fixed-latency busy window.
// Define MDU_DIV_EN to compile in the divider; without it div/divu are dropped as reserved.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state  | meaning
    // S_IDLE | no operation in flight, requests may be accepted
    // S_BUSY | multiply/divide in flight, cnt_q counts down to completion
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic               capture, done, wr_hi, wr_lo;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        done    = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (mdu_op)
                        OP_MULT, OP_MULTU: begin
                            capture = 1'b1;
                            state_d = S_BUSY;
                            cnt_d   = 8'(MULT_CYCLES);
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                            capture = 1'b1;
                            state_d = S_BUSY;
                            cnt_d   = 8'(DIV_CYCLES);
`endif
                        end
                        OP_MTHI: wr_hi = 1'b1;
                        OP_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_BUSY);

    // Low 2W bits of the extended product equal the signed product.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

`ifdef MDU_DIV_EN
    // Signed divide on magnitudes; MIN / -1 wraps back to MIN with zero remainder.
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;

    always_comb begin
        a_neg   = a_q[WIDTH-1];
        b_neg   = b_q[WIDTH-1];
        b_zero  = (b_q == '0);
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        quo_mag = b_zero ? '0 : a_mag / b_mag;
        rem_mag = b_zero ? '0 : a_mag % b_mag;
        quo_s   = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
        rem_s   = a_neg ? -rem_mag : rem_mag;
        quo_u   = b_zero ? '0 : a_q / b_q;
        rem_u   = b_zero ? '0 : a_q % b_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'd0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= mdu_op;
            end
            if (done) begin
                case (op_q)
                    OP_MULT:  {hi, lo} <= prod_s;
                    OP_MULTU: {hi, lo} <= prod_u;
`ifdef MDU_DIV_EN
                    OP_DIV: begin
                        if (!b_zero) begin
                            hi <= rem_s;
                            lo <= quo_s;
                        end
                    end
                    OP_DIVU: begin
                        if (!b_zero) begin
                            hi <= rem_u;
                            lo <= quo_u;
                        end
                    end
`endif
                    default: ;
                endcase
            end else if (wr_hi) begin
                hi <= A;
            end else if (wr_lo) begin
                lo <= A;
            end
        end
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width in bits.
REQ-002 Parameter MULT_CYCLES, default 5, busy duration of mult/multu in cycles (legal range 1..255).
REQ-003 Parameter DIV_CYCLES, default 10, busy duration of div/divu in cycles (legal range 1..255).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled every rising edge.
REQ-007 mdu_op  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
REQ-008 A  input  WIDTH  first operand (dividend for divide; write data for mthi/mtlo).
REQ-009 B  input  WIDTH  second operand (divisor for divide).
REQ-010 busy  output  1  high while a multiply or divide is in flight.
REQ-011 hi  output  WIDTH  HI register, driven directly from a flop.
REQ-012 lo  output  WIDTH  LO register, driven directly from a flop.

Function
REQ-013 A request is accepted only when start=1, busy=0, reset=0 and mdu_op is 1..6; all other requests are dropped without side effect.
REQ-014 On acceptance of ops 1..4, A, B and the op are captured; later changes on A/B/mdu_op do not affect the result.
REQ-015 busy rises in the cycle after acceptance and stays high for exactly N cycles (N=MULT_CYCLES for 1/2, DIV_CYCLES for 3/4).
REQ-016 hi/lo take the new result on the same edge at which busy falls; the first cycle with busy=0 shows the new values.
REQ-017 mult: signed 2*WIDTH product, hi=upper WIDTH bits, lo=lower WIDTH bits; multu: same, unsigned.
REQ-018 div: lo=signed quotient truncated toward zero, hi=remainder carrying the dividend's sign; divu: unsigned quotient/remainder.
REQ-019 Divide with B=0: busy sequence unchanged, hi and lo keep their prior values at completion.
REQ-020 div with A=most-negative and B=-1: lo=most-negative value, hi=0, no other effect.
REQ-021 mthi/mtlo: hi (resp. lo) loaded with A on the accepting edge; busy stays 0; the other register is unchanged.
REQ-022 A start in the completion cycle (busy=1) is dropped; a start in the first busy=0 cycle is accepted.
REQ-023 hi and lo change only as specified in REQ-016, REQ-021 and Reset.

Reset
REQ-024 When reset=1 at a rising edge: busy=0, hi=0, lo=0, internal counter=0, captured operands cleared.
REQ-025 Reset during an in-flight operation discards that operation; no hi/lo update occurs afterwards.
REQ-026 reset=1 takes priority over start in the same cycle; the request is dropped.

Configuration
REQ-027 Macro MDU_DIV_EN defined: divide datapath compiled in; ops 3 and 4 behave per REQ-015..REQ-020.
REQ-028 MDU_DIV_EN undefined: no divider logic is present; ops 3 and 4 are treated as reserved (dropped, busy stays 0, hi/lo unchanged).

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10, MDU_DIV_EN defined unless stated)
REQ-029 mult A=0xFFFFFFFF B=0x2 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-030 div A=0xFFFFFFF9 B=0x2 -> busy high 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF; divu A=7 B=2 -> lo=3 hi=1.
REQ-031 mthi A=0x1234 then divu A=5 B=0 -> hi=0x1234 immediately, busy 10 cycles, hi/lo unchanged at completion.
REQ-032 mult accepted, mtlo A=0xAA issued on every busy cycle, operands toggled -> all mtlo dropped, lo equals product of captured operands.
REQ-033 mult A=3 B=4, reset on 3rd busy cycle -> next cycle busy=0 hi=0 lo=0, values remain 0 for 10 further cycles.
REQ-034 MDU_DIV_EN undefined, div A=8 B=2 -> busy never rises, hi/lo unchanged.
